// File: rtl/modexp_pkg.sv
// Shared constants and state encoding for the modexp feedback packer.
// Limb geometry is derived from the operand and feedback-FIFO widths.
package modexp_pkg;

    localparam int OPERAND_WIDTH = 256;
    localparam int LIMB_WIDTH    = 49;
    localparam int NUM_LIMBS     =
        (OPERAND_WIDTH + LIMB_WIDTH - 1) / LIMB_WIDTH;
    localparam int PAD_WIDTH     =
        NUM_LIMBS * LIMB_WIDTH - OPERAND_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/modexp_feedback_packer.sv
// Splits 256-bit operands into 49-bit limbs (LS first) for the feedback FIFO.
// Ports: clk, rst (async high); in_data/in_valid/in_ready operand handshake;
//   abort; fifo_din/fifo_wr_en/fifo_full FIFO write side;
//   busy, done, limb_idx, op_count status.
module modexp_feedback_packer #(
    parameter int OPERAND_WIDTH = modexp_pkg::OPERAND_WIDTH,
    parameter int LIMB_WIDTH    = modexp_pkg::LIMB_WIDTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     abort,
    output logic [LIMB_WIDTH-1:0]    fifo_din,
    output logic                     fifo_wr_en,
    input  logic                     fifo_full,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               limb_idx,
    output logic [CNT_WIDTH-1:0]     op_count
);
    import modexp_pkg::*;

    localparam int SR_W  = NUM_LIMBS * LIMB_WIDTH;
    localparam int PAD_W = SR_W - OPERAND_WIDTH;

    state_t          state;
    logic [SR_W-1:0] sr;
    logic            last;

    assign fifo_din   = sr[LIMB_WIDTH-1:0];
    assign in_ready   = (state == ST_IDLE);
    assign busy       = (state == ST_SEND);
    assign last       = (limb_idx == 3'(NUM_LIMBS - 1));
    // fifo_full is registered in the FIFO, so this path has no loop.
    assign fifo_wr_en = (state == ST_SEND) && !fifo_full && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sr       <= '0;
            limb_idx <= '0;
            done     <= 1'b0;
            op_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // abort wins over a same-cycle accept
                    if (in_valid && !abort) begin
                        sr       <= {{PAD_W{1'b0}}, in_data};
                        limb_idx <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (fifo_wr_en) begin
                        sr <= sr >> LIMB_WIDTH;
                        if (last) begin
                            // index parks at 0 so it never leaves 0..5
                            limb_idx <= '0;
                            state    <= ST_IDLE;
                            done     <= 1'b1;
                            op_count <= op_count + CNT_WIDTH'(1);
                        end else begin
                            limb_idx <= limb_idx + 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_feedback_packer.sv
// Self-checking bench for modexp_feedback_packer.
// Reference: limbs computed arithmetically from each operand.
module tb_modexp_feedback_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [48:0]  fifo_din;
    logic         fifo_wr_en;
    logic         fifo_full;
    logic         busy;
    logic         done;
    logic [2:0]   limb_idx;
    logic [15:0]  op_count;

    logic         in_ready_w;
    logic [48:0]  fifo_din_w;
    logic         fifo_wr_en_w;
    logic         busy_w;
    logic         done_w;
    logic [2:0]   limb_idx_w;
    logic [2:0]   op_count_w;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    int cnt_model = 0;
    logic [48:0] expq[$];
    int          exp_idx[$];

    modexp_feedback_packer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .busy(busy),
        .done(done), .limb_idx(limb_idx), .op_count(op_count)
    );

    // Narrow counter copy so counter wrap is reachable in few operands.
    modexp_feedback_packer #(.CNT_WIDTH(3)) dut_w (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w), .abort(abort), .fifo_din(fifo_din_w),
        .fifo_wr_en(fifo_wr_en_w), .fifo_full(fifo_full),
        .busy(busy_w), .done(done_w), .limb_idx(limb_idx_w),
        .op_count(op_count_w)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] limb(logic [255:0] op, int k);
        logic [293:0] x;
        x = {38'b0, op};
        x = x >> (49 * k);
        return x[48:0];
    endfunction

    function automatic logic [255:0] rand_op();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_op(logic [255:0] op);
        for (int k = 0; k < 6; k++) begin
            expq.push_back(limb(op, k));
            exp_idx.push_back(k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_wr_en"}, fifo_wr_en, 0);
        check({tag, "_din"}, fifo_din, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_limb_idx"}, limb_idx, 0);
        check({tag, "_op_count"}, op_count, 0);
        check({tag, "_op_count_w"}, op_count_w, 0);
    endtask

    // Every write is matched against the next expected limb.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (fifo_full) check("wr_while_full", fifo_wr_en, 0);
            if (fifo_wr_en) begin
                writes++;
                if (expq.size() == 0) begin
                    check("unexpected_write", fifo_din, 64'hDEAD);
                end else begin
                    check("limb_data", fifo_din, expq.pop_front());
                    check("limb_idx", limb_idx, exp_idx.pop_front());
                end
            end
        end
    end

    task automatic run_op(logic [255:0] op, int stall_at, int stall_len,
                          int abort_at);
        int k;
        int stalls;
        int cycles;
        in_data  = op;
        in_valid = 1'b1;
        push_op(op);
        tick();
        in_valid = 1'b0;
        k = 0;
        stalls = stall_len;
        cycles = 0;
        while (k < 6 && cycles < 50) begin
            cycles++;
            if (k == abort_at) begin
                abort = 1'b1;
                nedge();
                check("abort_no_write", fifo_wr_en, 0);
                tick();
                abort = 1'b0;
                nedge();
                check("abort_idle", in_ready, 1);
                check("abort_no_done", done, 0);
                check("abort_count", op_count, 64'(cnt_model % 65536));
                expq.delete();
                exp_idx.delete();
                return;
            end
            if (k == stall_at && stalls > 0) begin
                fifo_full = 1'b1;
                nedge();
                check("stall_idx", limb_idx, 64'(k));
                check("stall_din", fifo_din, limb(op, k));
                check("stall_busy", busy, 1);
                stalls--;
                tick();
            end else begin
                fifo_full = 1'b0;
                nedge();
                check("write_en", fifo_wr_en, 1);
                check("busy", busy, 1);
                check("done_low", done, 0);
                tick();
                k++;
            end
        end
        fifo_full = 1'b0;
        cnt_model++;
        nedge();
        check("done_pulse", done, 1);
        check("ready_after", in_ready, 1);
        check("latency", 64'(cycles), 64'(6 + stall_len));
        check("op_count", op_count, 64'(cnt_model % 65536));
        check("op_count_w", op_count_w, 64'(cnt_model % 8));
        check("queue_drained", 64'(expq.size()), 0);
        tick();
        nedge();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a;
        logic [255:0] b;
        int w0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        abort     = 1'b0;
        fifo_full = 1'b0;
        in_data   = '0;
        nedge();
        check_reset("reset");
        tick();
        rst = 1'b0;
        nedge();
        check("ready_after_release", in_ready, 1);

        // Full-pattern operand, no stalls
        a = {4{64'h0123456789ABCDEF}};
        run_op(a, -1, 0, -1);

        // Three-cycle stall while limb 2 is presented
        run_op(rand_op(), 2, 3, -1);

        // Back-to-back operands with in_valid held high
        a = rand_op();
        b = rand_op();
        w0 = writes;
        in_data  = a;
        in_valid = 1'b1;
        push_op(a);
        tick();
        in_data = b;
        push_op(b);
        for (int i = 1; i <= 7; i++) begin
            nedge();
            if (i < 7) begin
                check("b2b_not_ready", in_ready, 0);
            end else begin
                check("b2b_ready_at_7", in_ready, 1);
                check("b2b_done_a", done, 1);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            nedge();
            if (j == 7) begin
                check("b2b_done_b", done, 1);
                check("b2b_ready_b", in_ready, 1);
            end
            tick();
        end
        cnt_model += 2;
        check("b2b_writes", 64'(writes - w0), 12);
        check("b2b_op_count", op_count, 64'(cnt_model % 65536));

        // Reset while limb 3 is presented
        in_data  = rand_op();
        in_valid = 1'b1;
        push_op(in_data);
        tick();
        in_valid = 1'b0;
        repeat (3) begin
            nedge();
            tick();
        end
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        expq.delete();
        exp_idx.delete();
        cnt_model = 0;
        nedge();
        tick();
        rst = 1'b0;
        nedge();
        check("ready_after_mid_reset", in_ready, 1);
        check("count_after_mid_reset", op_count, 0);

        // Abort while limb 3 is presented, then a clean operand
        run_op(rand_op(), -1, 0, 3);
        run_op(rand_op(), -1, 0, -1);

        // Abort in IDLE beats a same-cycle accept
        in_data  = rand_op();
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        nedge();
        check("idle_abort_busy", busy, 0);
        check("idle_abort_ready", in_ready, 1);
        in_valid = 1'b0;
        abort    = 1'b0;
        tick();
        nedge();
        check("idle_abort_still_idle", busy, 0);

        // Random operands and stalls; crosses the narrow counter wrap
        for (int n = 0; n < 9; n++) begin
            run_op(rand_op(), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 3)), -1);
        end
        check("final_queue_empty", 64'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
